// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states and
// byte-lane extract/merge helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StMerge = 2'd2,
        StDone  = 2'd3
    } dmem_state_e;

    // Offset bits that may be non-zero for an access of the given size (funct3[1:0]).
    function automatic logic [2:0] offset_mask(input logic [1:0] size);
        case (size)
            2'b00:   offset_mask = 3'b111;
            2'b01:   offset_mask = 3'b110;
            2'b10:   offset_mask = 3'b100;
            default: offset_mask = 3'b000;
        endcase
    endfunction

    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        case (size)
            2'b00:   lane_mask = 64'h0000_0000_0000_00FF;
            2'b01:   lane_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic [63:0] load_extract(input logic [63:0] dword,
                                                 input logic [2:0]  off,
                                                 input logic [2:0]  f3);
        logic [63:0] sh;
        sh = dword >> {off, 3'b000};
        case (f3)
            F3_B:    load_extract = {{56{sh[7]}}, sh[7:0]};
            F3_H:    load_extract = {{48{sh[15]}}, sh[15:0]};
            F3_W:    load_extract = {{32{sh[31]}}, sh[31:0]};
            F3_BU:   load_extract = {56'd0, sh[7:0]};
            F3_HU:   load_extract = {48'd0, sh[15:0]};
            F3_WU:   load_extract = {32'd0, sh[31:0]};
            default: load_extract = sh;
        endcase
    endfunction

    function automatic logic [63:0] store_merge(input logic [63:0] dword,
                                                input logic [2:0]  off,
                                                input logic [1:0]  size,
                                                input logic [63:0] wdata);
        logic [63:0] m;
        m = lane_mask(size) << {off, 3'b000};
        store_merge = (dword & ~m) | ((wdata << {off, 3'b000}) & m);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM, DEPTH x 64, registered read; read and write of the
// same word never coincide, so read-during-write order does not matter.
module dmem_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [63:0]   wdata_i,
    output logic [63:0]   rdata_o
);

    logic [63:0] mem [DEPTH];
    logic [63:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: load/store FSM over dmem_ram with RMW for narrow stores.
// Define DMEM_ALIGN_CHECK_EN to enable error detection; otherwise accesses are coerced.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_mem_r,
    input  logic        ctrl_mem_w,
    input  logic [2:0]  funct3,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        mem_done,
    output logic        mem_err,
    output logic        mem_stall
);

    dmem_state_e   state_q;
    logic [AW-1:0] idx_q;
    logic [2:0]    off_q;
    logic [2:0]    f3_q;
    logic [63:0]   wdata_q;
    logic [63:0]   rdata_q;
    logic          done_q;
    logic          err_q;

    logic          req;
    logic          is_load;
    logic          req_err;
    logic [2:0]    f3_eff;
    logic [2:0]    off_eff;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [63:0]   ram_wdata;
    logic [63:0]   ram_rdata;

    assign req = ctrl_mem_r | ctrl_mem_w;

    // Normalise the access so the default build can coerce illegal encodings;
    // with checking enabled those encodings are errored before use.
    always_comb begin
        is_load = ctrl_mem_r;
        f3_eff  = funct3;
        if (!is_load) begin
            f3_eff = {1'b0, funct3[1:0]};
        end else if (funct3 == 3'b111) begin
            f3_eff = F3_D;
        end
        off_eff = addr[2:0] & offset_mask(f3_eff[1:0]);
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign req_err = (ctrl_mem_r & ctrl_mem_w)
                   | (funct3 == 3'b111)
                   | (ctrl_mem_w & funct3[2])
                   | ((addr[2:0] & ~offset_mask(funct3[1:0])) != 3'b000)
                   | (addr[63:AW+3] != '0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = |addr[63:AW+3];
    assign req_err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        idx_q   <= addr[AW+2:3];
                        off_q   <= off_eff;
                        f3_q    <= f3_eff;
                        wdata_q <= wdata;
                        if (req_err) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            if (ctrl_mem_r) begin
                                rdata_q <= '0;
                            end
                        end else if (is_load) begin
                            state_q <= StLoad;
                        end else if (f3_eff == F3_D) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StMerge;
                        end
                    end
                end
                StLoad: begin
                    rdata_q <= load_extract(ram_rdata, off_q, f3_q);
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                StMerge: begin
                    state_q <= StDone;
                    done_q  <= 1'b1;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Reset must also block a write issued in the same cycle.
    assign ram_we = rst_n & (((state_q == StIdle) & req & ~req_err & ~is_load & (f3_eff == F3_D))
                             | (state_q == StMerge));
    assign ram_addr  = (state_q == StIdle) ? addr[AW+2:3] : idx_q;
    assign ram_wdata = (state_q == StMerge) ? store_merge(ram_rdata, off_q, f3_q[1:0], wdata_q)
                                            : wdata;

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign rdata     = rdata_q;
    assign mem_done  = done_q;
    assign mem_err   = err_q;
    assign mem_stall = ((state_q == StIdle) & req) | (state_q == StLoad) | (state_q == StMerge);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl; expectations follow DMEM_ALIGN_CHECK_EN when defined.
module tb_dmem_ctrl;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        ctrl_mem_r;
    logic        ctrl_mem_w;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        mem_done;
    logic        mem_err;
    logic        mem_stall;

    int vectors;
    int miscompares;

    dmem_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ctrl_mem_r (ctrl_mem_r),
        .ctrl_mem_w (ctrl_mem_w),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .mem_done   (mem_done),
        .mem_err    (mem_err),
        .mem_stall  (mem_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Issues one request from IDLE (called #1 after a rising edge) and waits for mem_done.
    // lat counts rising edges from the accept edge (1 = visible right after accept).
    task automatic do_req(input logic r, input logic w, input logic [2:0] f3,
                          input logic [63:0] a, input logic [63:0] wd,
                          output int lat, output logic err, output logic [63:0] rd,
                          output logic [3:0] stall_v, output logic stall_done);
        logic done;
        done       = 1'b0;
        lat        = -1;
        err        = 1'bx;
        rd         = 'x;
        stall_v    = '0;
        stall_done = 1'bx;
        ctrl_mem_r = r;
        ctrl_mem_w = w;
        funct3     = f3;
        addr       = a;
        wdata      = wd;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (c < 4) stall_v[c] = mem_stall;
            @(posedge clk);
            #1;
            if (mem_done) begin
                done = 1'b1;
                lat  = c + 1;
                err  = mem_err;
                rd   = rdata;
            end
        end
        if (done) begin
            @(negedge clk);
            stall_done = mem_stall;
        end
        ctrl_mem_r = 1'b0;
        ctrl_mem_w = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        ctrl_mem_r = 1'b0;
        ctrl_mem_w = 1'b0;
        funct3     = 3'b000;
        addr       = '0;
        wdata      = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (rdata !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_rdata: got %h required %h", rdata, 64'd0);
        end
        vectors++;
        if (mem_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_done: got %b required 0", mem_done);
        end
        vectors++;
        if (mem_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b required 0", mem_err);
        end
        vectors++;
        if (mem_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_stall: got %b required 0", mem_stall);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_sd_ld();
        int lat; logic err; logic [63:0] rd; logic [3:0] sv; logic sd;
        do_req(1'b0, 1'b1, 3'b011, 64'h10, 64'h1122334455667788, lat, err, rd, sv, sd);
        vectors++;
        if (lat !== 1 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL sd_latency: got lat=%0d err=%b required lat=1 err=0", lat, err);
        end
        do_req(1'b1, 1'b0, 3'b011, 64'h10, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (lat !== 2 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL ld_latency: got lat=%0d err=%b required lat=2 err=0", lat, err);
        end
        vectors++;
        if (rd !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL ld_data: got %h required %h", rd, 64'h1122334455667788);
        end
        vectors++;
        if (sv[1:0] !== 2'b11 || sd !== 1'b0) begin
            miscompares++;
            $display("FAIL ld_stall: got %b/%b required 11/0", sv[1:0], sd);
        end
    endtask

    task automatic test_byte_store();
        int lat; logic err; logic [63:0] rd; logic [3:0] sv; logic sd;
        do_req(1'b0, 1'b1, 3'b000, 64'h13, 64'hAB, lat, err, rd, sv, sd);
        vectors++;
        if (lat !== 2 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL sb_latency: got lat=%0d err=%b required lat=2 err=0", lat, err);
        end
        vectors++;
        if (rdata !== 64'h1122334455667788) begin
            miscompares++;
            $display("FAIL sb_rdata_hold: got %h required %h", rdata, 64'h1122334455667788);
        end
        do_req(1'b1, 1'b0, 3'b011, 64'h10, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (rd !== 64'h11223344AB667788) begin
            miscompares++;
            $display("FAIL sb_merge: got %h required %h", rd, 64'h11223344AB667788);
        end
        do_req(1'b1, 1'b0, 3'b000, 64'h13, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (rd !== 64'hFFFFFFFFFFFFFFAB) begin
            miscompares++;
            $display("FAIL lb: got %h required %h", rd, 64'hFFFFFFFFFFFFFFAB);
        end
        do_req(1'b1, 1'b0, 3'b100, 64'h13, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (rd !== 64'h00000000000000AB) begin
            miscompares++;
            $display("FAIL lbu: got %h required %h", rd, 64'h00000000000000AB);
        end
    endtask

    task automatic test_word();
        int lat; logic err; logic [63:0] rd; logic [3:0] sv; logic sd;
        do_req(1'b0, 1'b1, 3'b011, 64'h20, 64'h0123456789ABCDEF, lat, err, rd, sv, sd);
        do_req(1'b0, 1'b1, 3'b010, 64'h24, 64'h80000000, lat, err, rd, sv, sd);
        vectors++;
        if (lat !== 2 || sv[1:0] !== 2'b11 || sd !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_timing: got lat=%0d stall=%b/%b required lat=2 stall=11/0",
                     lat, sv[1:0], sd);
        end
        do_req(1'b1, 1'b0, 3'b010, 64'h24, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (rd !== 64'hFFFFFFFF80000000) begin
            miscompares++;
            $display("FAIL lw: got %h required %h", rd, 64'hFFFFFFFF80000000);
        end
        do_req(1'b1, 1'b0, 3'b110, 64'h24, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (rd !== 64'h0000000080000000) begin
            miscompares++;
            $display("FAIL lwu: got %h required %h", rd, 64'h0000000080000000);
        end
        do_req(1'b1, 1'b0, 3'b011, 64'h20, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (rd !== 64'h8000000089ABCDEF) begin
            miscompares++;
            $display("FAIL sw_merge: got %h required %h", rd, 64'h8000000089ABCDEF);
        end
    endtask

`ifdef DMEM_ALIGN_CHECK_EN
    task automatic test_errors();
        int lat; logic err; logic [63:0] rd; logic [3:0] sv; logic sd;
        do_req(1'b1, 1'b0, 3'b001, 64'h21, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (lat !== 1 || err !== 1'b1 || rd !== 64'd0) begin
            miscompares++;
            $display("FAIL lh_misalign: got lat=%0d err=%b rd=%h required 1/1/0", lat, err, rd);
        end
        do_req(1'b0, 1'b1, 3'b010, 64'h22, 64'hDEADBEEF, lat, err, rd, sv, sd);
        vectors++;
        if (lat !== 1 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL sw_misalign: got lat=%0d err=%b required 1/1", lat, err);
        end
        do_req(1'b1, 1'b0, 3'b011, 64'h20, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (rd !== 64'h8000000089ABCDEF || err !== 1'b0) begin
            miscompares++;
            $display("FAIL sw_misalign_noop: got %h required %h", rd, 64'h8000000089ABCDEF);
        end
        do_req(1'b1, 1'b0, 3'b011, 64'(DEPTH) << 3, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (err !== 1'b1 || rd !== 64'd0) begin
            miscompares++;
            $display("FAIL ld_range: got err=%b rd=%h required 1/0", err, rd);
        end
        do_req(1'b1, 1'b1, 3'b011, 64'h20, 64'h5555, lat, err, rd, sv, sd);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL both_strobes: got err=%b required 1", err);
        end
        do_req(1'b1, 1'b0, 3'b011, 64'h20, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (rd !== 64'h8000000089ABCDEF) begin
            miscompares++;
            $display("FAIL both_strobes_noop: got %h required %h", rd, 64'h8000000089ABCDEF);
        end
    endtask
`else
    task automatic test_errors();
        int lat; logic err; logic [63:0] rd; logic [3:0] sv; logic sd;
        do_req(1'b1, 1'b0, 3'b001, 64'h21, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (lat !== 2 || err !== 1'b0 || rd !== 64'hFFFFFFFFFFFFCDEF) begin
            miscompares++;
            $display("FAIL lh_round: got lat=%0d err=%b rd=%h required 2/0/%h",
                     lat, err, rd, 64'hFFFFFFFFFFFFCDEF);
        end
        do_req(1'b1, 1'b0, 3'b011, (64'(DEPTH) << 3) + 64'h10, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (err !== 1'b0 || rd !== 64'h11223344AB667788) begin
            miscompares++;
            $display("FAIL ld_wrap: got err=%b rd=%h required 0/%h", err, rd, 64'h11223344AB667788);
        end
        do_req(1'b1, 1'b1, 3'b011, 64'h20, 64'h5555, lat, err, rd, sv, sd);
        vectors++;
        if (lat !== 2 || err !== 1'b0 || rd !== 64'h8000000089ABCDEF) begin
            miscompares++;
            $display("FAIL both_as_load: got lat=%0d err=%b rd=%h required 2/0/%h",
                     lat, err, rd, 64'h8000000089ABCDEF);
        end
    endtask
`endif

    task automatic test_reset_merge();
        int lat; logic err; logic [63:0] rd; logic [3:0] sv; logic sd;
        do_req(1'b0, 1'b1, 3'b011, 64'h30, 64'hCAFEF00D12345678, lat, err, rd, sv, sd);
        ctrl_mem_w = 1'b1;
        funct3     = 3'b001;
        addr       = 64'h30;
        wdata      = 64'hBEEF;
        @(posedge clk);
        #1;
        vectors++;
        if (mem_stall !== 1'b1) begin
            miscompares++;
            $display("FAIL merge_stall: got %b required 1", mem_stall);
        end
        rst_n      = 1'b0;
        ctrl_mem_w = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (mem_done !== 1'b0 || mem_stall !== 1'b0 || rdata !== 64'd0) begin
            miscompares++;
            $display("FAIL merge_reset: got done=%b stall=%b rdata=%h required 0/0/0",
                     mem_done, mem_stall, rdata);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (mem_done !== 1'b0) begin
            miscompares++;
            $display("FAIL merge_reset_idle: got done=%b required 0", mem_done);
        end
        do_req(1'b1, 1'b0, 3'b011, 64'h30, 64'h0, lat, err, rd, sv, sd);
        vectors++;
        if (lat !== 2 || rd !== 64'hCAFEF00D12345678) begin
            miscompares++;
            $display("FAIL merge_reset_data: got lat=%0d rd=%h required 2/%h",
                     lat, rd, 64'hCAFEF00D12345678);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  done_v;
        logic [8:0]  stall_v;
        logic [63:0] last_rd;
        done_v     = '0;
        stall_v    = '0;
        last_rd    = '0;
        ctrl_mem_r = 1'b1;
        funct3     = 3'b011;
        addr       = 64'h10;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            stall_v[i] = mem_stall;
            @(posedge clk);
            #1;
            done_v[i] = mem_done;
            if (mem_done) last_rd = rdata;
        end
        ctrl_mem_r = 1'b0;
        vectors++;
        if (done_v !== 9'b010010010) begin
            miscompares++;
            $display("FAIL b2b_done: got %b required %b", done_v, 9'b010010010);
        end
        vectors++;
        if (stall_v !== 9'b011011011) begin
            miscompares++;
            $display("FAIL b2b_stall: got %b required %b", stall_v, 9'b011011011);
        end
        vectors++;
        if (last_rd !== 64'h11223344AB667788) begin
            miscompares++;
            $display("FAIL b2b_data: got %h required %h", last_rd, 64'h11223344AB667788);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_sd_ld();
        test_byte_store();
        test_word();
        test_errors();
        test_reset_merge();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory responder for the 64-bit RV64 core; the consumer end of the decoder's `ctrl_mem_r` / `ctrl_mem_w` strobes.
- Accepts load/store requests (address from ALU, store data from rs2, width from funct3) and performs them on an internal single-port synchronous RAM.
- Sub-doubleword stores use read-modify-write; loads are size-extracted and sign/zero-extended.
- Holds the core via `mem_stall` until `mem_done`.

Parameters:
- `DEPTH`, 1024, number of 64-bit doublewords in RAM (power of 2).
- `AW`, `$clog2(DEPTH)`, doubleword index width, derived.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `ctrl_mem_r`  in  1  load request, level.
- `ctrl_mem_w`  in  1  store request, level.
- `funct3`  in  3  access width/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- `addr`  in  64  byte address.
- `wdata`  in  64  store data, LSB-aligned.
- `rdata`  out  64  load result, registered.
- `mem_done`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  error flag, valid with `mem_done`.
- `mem_stall`  out  1  core must hold PC and inputs.

Behaviour:
- Reset (`rst_n`=0 at edge): state IDLE; `rdata`, `mem_done`, `mem_err` = 0.
  - Highest priority; aborts any operation and suppresses a pending RAM write in that cycle.
  - RAM contents are not reset.
- Request is valid in IDLE when `ctrl_mem_r` ^ `ctrl_mem_w`. Both high: error. Inputs are latched on acceptance.
- States: IDLE, LOAD, MERGE, DONE.
- IDLE, load: issue RAM read at `addr[AW+2:3]` -> LOAD.
- IDLE, store with funct3=011: write `wdata` full -> DONE.
- IDLE, store with funct3 000/001/010: issue RAM read -> MERGE.
- LOAD: select bytes at offset `addr[2:0]`, sign-extend (B/H/W) or zero-extend (BU/HU/WU/D), register into `rdata` -> DONE.
- MERGE: replace 1/2/4 bytes at offset with `wdata` low bytes, write back -> DONE.
- DONE: `mem_done`=1 for exactly one cycle -> IDLE. Next request is accepted no earlier than the following cycle.
- Latency from the accept edge:
  - Load: `mem_done` at accept+2.
  - SD: accept+1.
  - SB/SH/SW: accept+2.
- `mem_stall` (combinational) = (IDLE & request present) | (state ∈ {LOAD, MERGE}). It is 0 in DONE and in IDLE with no request.
- `rdata` holds its last load value until the next load completes. It is unchanged by stores and set to 0 on an errored load.
- Errors (go directly to DONE, `mem_err`=1, no RAM write, no RAM read result):
  - Both strobes high.
  - funct3=111.
  - Store funct3 ≥ 100.
  - Misaligned address (H: `addr[0]`; W: `addr[1:0]`≠0; D: `addr[2:0]`≠0).
  - `addr[63:AW+3]` ≠ 0.
- `mem_err` = 0 whenever `mem_done` = 0.

Optional Feature:
- Macro `DMEM_ALIGN_CHECK_EN`.
- Defined: all error checks above active.
- Undefined:
  - `mem_err` is tied 0.
  - Misaligned addresses are rounded down to the access size.
  - Upper address bits are ignored (index wraps modulo `DEPTH`).
  - Both-strobes-high is treated as a load.
  - funct3=111 is treated as D; store funct3 ≥ 100 is treated as its low 2 bits.

Decomposition:
- Package `dmem_pkg`: funct3 width codes (F3_B…F3_WU), state enum encoding, byte-lane extract/extend and merge functions.
- Sub-module `dmem_ram`: single-port synchronous RAM, `DEPTH`x64, registered read, write-first irrelevant (never read and written in the same cycle).

Test Plan:
- SD `addr`=0x10, `wdata`=0x1122334455667788, then LD `addr`=0x10 -> `mem_done` at accept+1 for the store and accept+2 for the load; `rdata`=0x1122334455667788; `mem_err`=0.
- After the above, SB `addr`=0x13 `wdata`=0xAB, then LD 0x10 -> `rdata`=0x11223344AB667788; then LB 0x13 -> 0xFFFFFFFFFFFFFFAB; LBU 0x13 -> 0x00000000000000AB.
- SW 0x24 `wdata`=0x80000000, LW 0x24 -> 0xFFFFFFFF80000000; LWU 0x24 -> 0x0000000080000000; `mem_stall` high exactly during accept and LOAD cycles.
- With `DMEM_ALIGN_CHECK_EN`: LH 0x21, SW 0x22, LD `addr`=DEPTH*8, both strobes high -> each gives `mem_err`=1 with `mem_done`, no RAM change (verify by a re-read), `rdata`=0 for loads. Without the macro: LH 0x21 returns the halfword at 0x20, `mem_err`=0.
- `rst_n`=0 during the MERGE cycle of SH 0x30 -> state IDLE, no `mem_done`, the doubleword at 0x30 keeps its prior value; the next request is serviced normally.
- Back-to-back loads with strobes held: second request accepted the cycle after DONE; `mem_done` pulses are never longer than one cycle.
